// File: rtl/register_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard: entry state, entry record, operand bit positions.
package register_scoreboard_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned LAT_W        = 3;
  localparam int unsigned NUM_REGS     = 2 ** REG_W;
  localparam int unsigned NUM_OPS      = 3;
  localparam int unsigned STALL_CNT_W  = 32;
  localparam int unsigned ORPHAN_CNT_W = 16;

  localparam int unsigned OP_D = 0;
  localparam int unsigned OP_S = 1;
  localparam int unsigned OP_T = 2;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_WAIT  = 2'd1,
    SB_READY = 2'd2
  } sb_state_t;

  typedef struct packed {
    sb_state_t         state;
    logic [LAT_W-1:0]  count;
  } sb_entry_t;

  localparam sb_entry_t SB_ENTRY_IDLE = '{state: SB_IDLE, count: '0};

endpackage

// File: rtl/register_scoreboard_if.sv
// Decode/writeback-side bundle for the register scoreboard.
// SCOREBOARD_STATS_EN adds the stall_cycles / wb_orphans counters.
interface register_scoreboard_if;
  import register_scoreboard_pkg::*;

  logic                 issue_valid;
  logic [REG_W-1:0]     issue_d;
  logic                 issue_to_gd;
  logic                 issue_to_fd;
  logic [LAT_W-1:0]     issue_lat;
  logic                 wb_valid;
  logic [REG_W-1:0]     wb_d;
  logic                 wb_to_gd;
  logic                 wb_to_fd;
  logic                 flush;
  logic [REG_W-1:0]     chk_d;
  logic [REG_W-1:0]     chk_s;
  logic [REG_W-1:0]     chk_t;
  logic [NUM_OPS-1:0]   chk_from_g;
  logic [NUM_OPS-1:0]   chk_from_f;
  logic                 stall;
  logic [NUM_REGS-1:0]  busy_g;
  logic [NUM_REGS-1:0]  busy_f;
`ifdef SCOREBOARD_STATS_EN
  logic [STALL_CNT_W-1:0]  stall_cycles;
  logic [ORPHAN_CNT_W-1:0] wb_orphans;
`endif

  modport master (
    output issue_valid, issue_d, issue_to_gd, issue_to_fd, issue_lat,
    output wb_valid, wb_d, wb_to_gd, wb_to_fd, flush,
    output chk_d, chk_s, chk_t, chk_from_g, chk_from_f,
`ifdef SCOREBOARD_STATS_EN
    input  stall_cycles, wb_orphans,
`endif
    input  stall, busy_g, busy_f
  );

  modport slave (
    input  issue_valid, issue_d, issue_to_gd, issue_to_fd, issue_lat,
    input  wb_valid, wb_d, wb_to_gd, wb_to_fd, flush,
    input  chk_d, chk_s, chk_t, chk_from_g, chk_from_f,
`ifdef SCOREBOARD_STATS_EN
    output stall_cycles, wb_orphans,
`endif
    output stall, busy_g, busy_f
  );

endinterface

// File: rtl/register_scoreboard_entry.sv
// One scoreboard entry: tracks a single register's pending producer and its latency countdown.
module scoreboard_entry
  import register_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_hit,
  input  logic [LAT_W-1:0] lat,
  input  logic             wb_hit,
  input  logic             flush,
  output sb_state_t        state
);

  sb_entry_t ent_q, ent_d;

  // Priority: flush, then a new issue (supersedes a same-cycle writeback), then writeback, then countdown.
  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d = SB_ENTRY_IDLE;
    end else if (issue_hit) begin
      ent_d.count = lat;
      ent_d.state = (lat == LAT_W'(0)) ? SB_READY : SB_WAIT;
    end else if (wb_hit && (ent_q.state != SB_IDLE)) begin
      ent_d = SB_ENTRY_IDLE;
    end else if (ent_q.state == SB_WAIT) begin
      if (ent_q.count <= LAT_W'(1)) begin
        ent_d.count = '0;
        ent_d.state = SB_READY;
      end else begin
        ent_d.count = ent_q.count - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= SB_ENTRY_IDLE;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign state = ent_q.state;

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard for g and f files: records in-flight producers and stalls decode on unready sources.
// Define SCOREBOARD_STATS_EN to add saturating stall_cycles and wb_orphans counters.
module register_scoreboard
  import register_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  register_scoreboard_if.slave sb
);

  logic                issue_acc;
  logic                stall_c;
  logic [NUM_REGS-1:0] busy_g;
  logic [NUM_REGS-1:0] busy_f;
  logic [NUM_REGS-1:0] wait_g;
  logic [NUM_REGS-1:0] wait_f;

  assign issue_acc = sb.issue_valid && !stall_c && !sb.flush;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entries
    sb_state_t st_g;
    sb_state_t st_f;

    scoreboard_entry u_entry_g (
      .clk       (clk),
      .rst       (rst),
      .issue_hit (issue_acc && sb.issue_to_gd && (sb.issue_d == REG_W'(i))),
      .lat       (sb.issue_lat),
      .wb_hit    (sb.wb_valid && sb.wb_to_gd && (sb.wb_d == REG_W'(i))),
      .flush     (sb.flush),
      .state     (st_g)
    );

    scoreboard_entry u_entry_f (
      .clk       (clk),
      .rst       (rst),
      .issue_hit (issue_acc && sb.issue_to_fd && (sb.issue_d == REG_W'(i))),
      .lat       (sb.issue_lat),
      .wb_hit    (sb.wb_valid && sb.wb_to_fd && (sb.wb_d == REG_W'(i))),
      .flush     (sb.flush),
      .state     (st_f)
    );

    assign busy_g[i] = (st_g != SB_IDLE);
    assign busy_f[i] = (st_f != SB_IDLE);
    assign wait_g[i] = (st_g == SB_WAIT);
    assign wait_f[i] = (st_f == SB_WAIT);
  end

  // Only WAIT entries stall; READY results are picked up by forwarding.
  always_comb begin
    stall_c = 1'b0;
    if (sb.chk_from_g[OP_D] && wait_g[sb.chk_d]) stall_c = 1'b1;
    if (sb.chk_from_g[OP_S] && wait_g[sb.chk_s]) stall_c = 1'b1;
    if (sb.chk_from_g[OP_T] && wait_g[sb.chk_t]) stall_c = 1'b1;
    if (sb.chk_from_f[OP_D] && wait_f[sb.chk_d]) stall_c = 1'b1;
    if (sb.chk_from_f[OP_S] && wait_f[sb.chk_s]) stall_c = 1'b1;
    if (sb.chk_from_f[OP_T] && wait_f[sb.chk_t]) stall_c = 1'b1;
  end

  assign sb.stall  = stall_c;
  assign sb.busy_g = busy_g;
  assign sb.busy_f = busy_f;

`ifdef SCOREBOARD_STATS_EN
  logic [STALL_CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [ORPHAN_CNT_W-1:0] wb_orphans_q, wb_orphans_d;
  logic                    orphan_g;
  logic                    orphan_f;
  logic [ORPHAN_CNT_W:0]   orphan_sum;

  // A dual-file writeback can hit two idle entries, so orphans add up to two per cycle.
  always_comb begin
    orphan_g   = sb.wb_valid && sb.wb_to_gd && !busy_g[sb.wb_d];
    orphan_f   = sb.wb_valid && sb.wb_to_fd && !busy_f[sb.wb_d];
    orphan_sum = (ORPHAN_CNT_W+1)'(wb_orphans_q) + (ORPHAN_CNT_W+1)'(orphan_g)
               + (ORPHAN_CNT_W+1)'(orphan_f);
    wb_orphans_d   = orphan_sum[ORPHAN_CNT_W] ? '1 : orphan_sum[ORPHAN_CNT_W-1:0];
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      wb_orphans_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      wb_orphans_q   <= wb_orphans_d;
    end
  end

  assign sb.stall_cycles = stall_cycles_q;
  assign sb.wb_orphans   = wb_orphans_q;
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed self-checking bench for register_scoreboard (g/f producer tracking and decode stall).
module tb_register_scoreboard;
  import register_scoreboard_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  register_scoreboard_if sb_if ();

  register_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    sb_if.issue_valid = 1'b0;
    sb_if.issue_d     = '0;
    sb_if.issue_to_gd = 1'b0;
    sb_if.issue_to_fd = 1'b0;
    sb_if.issue_lat   = '0;
    sb_if.wb_valid    = 1'b0;
    sb_if.wb_d        = '0;
    sb_if.wb_to_gd    = 1'b0;
    sb_if.wb_to_fd    = 1'b0;
    sb_if.flush       = 1'b0;
    sb_if.chk_d       = '0;
    sb_if.chk_s       = '0;
    sb_if.chk_t       = '0;
    sb_if.chk_from_g  = '0;
    sb_if.chk_from_f  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [REG_W-1:0] d, input logic g, input logic f,
                       input logic [LAT_W-1:0] lat);
    sb_if.issue_valid = 1'b1;
    sb_if.issue_d     = d;
    sb_if.issue_to_gd = g;
    sb_if.issue_to_fd = f;
    sb_if.issue_lat   = lat;
  endtask

  task automatic wb(input logic [REG_W-1:0] d, input logic g, input logic f);
    sb_if.wb_valid = 1'b1;
    sb_if.wb_d     = d;
    sb_if.wb_to_gd = g;
    sb_if.wb_to_fd = f;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    checks++; if (sb_if.busy_g !== '0) begin failures++; $display("FAIL reset_busy_g got=%h exp=0", sb_if.busy_g); end
    checks++; if (sb_if.busy_f !== '0) begin failures++; $display("FAIL reset_busy_f got=%h exp=0", sb_if.busy_f); end
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", sb_if.stall); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_wait_countdown();
    issue(5'd3, 1'b1, 1'b0, 3'd2);
    step();
    clear_inputs();
    sb_if.chk_s = 5'd3; sb_if.chk_from_g = 3'b010;
    #1;
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL cnt_stall_c2 got=%b exp=1", sb_if.stall); end
    step();
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL cnt_stall_c1 got=%b exp=1", sb_if.stall); end
    step();
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL cnt_stall_ready got=%b exp=0", sb_if.stall); end
    checks++; if (sb_if.busy_g !== 32'h0000_0008) begin failures++; $display("FAIL cnt_busy_ready got=%h exp=00000008", sb_if.busy_g); end
    step();
    checks++; if (sb_if.busy_g !== 32'h0000_0008) begin failures++; $display("FAIL cnt_busy_hold got=%h exp=00000008", sb_if.busy_g); end
    clear_inputs();
    wb(5'd3, 1'b1, 1'b0);
    step();
    clear_inputs();
    checks++; if (sb_if.busy_g !== '0) begin failures++; $display("FAIL cnt_busy_wb got=%h exp=0", sb_if.busy_g); end
  endtask

  task automatic test_file_isolation();
    issue(5'd5, 1'b0, 1'b1, 3'd0);
    step();
    clear_inputs();
    sb_if.chk_t = 5'd5; sb_if.chk_from_f = 3'b100;
    #1;
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL iso_ready_stall got=%b exp=0", sb_if.stall); end
    checks++; if (sb_if.busy_f !== 32'h0000_0020) begin failures++; $display("FAIL iso_busy_f got=%h exp=00000020", sb_if.busy_f); end
    checks++; if (sb_if.busy_g !== '0) begin failures++; $display("FAIL iso_busy_g got=%h exp=0", sb_if.busy_g); end
    // WAW re-issue turns the READY f entry back into WAIT.
    clear_inputs();
    issue(5'd5, 1'b0, 1'b1, 3'd3);
    step();
    clear_inputs();
    sb_if.chk_t = 5'd5; sb_if.chk_from_f = 3'b100;
    #1;
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL iso_waw_stall got=%b exp=1", sb_if.stall); end
    sb_if.chk_from_f = 3'b000; sb_if.chk_from_g = 3'b100;
    #1;
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL iso_g_side_stall got=%b exp=0", sb_if.stall); end
    clear_inputs();
    wb(5'd5, 1'b0, 1'b1);
    step();
    clear_inputs();
    checks++; if (sb_if.busy_f !== '0) begin failures++; $display("FAIL iso_wb_busy_f got=%h exp=0", sb_if.busy_f); end
  endtask

  task automatic test_issue_wb_same_cycle();
    issue(5'd7, 1'b1, 1'b0, 3'd3);
    wb(5'd7, 1'b1, 1'b0);
    step();
    clear_inputs();
    sb_if.chk_d = 5'd7; sb_if.chk_from_g = 3'b001;
    #1;
    checks++; if (sb_if.busy_g !== 32'h0000_0080) begin failures++; $display("FAIL same_busy got=%h exp=00000080", sb_if.busy_g); end
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL same_stall got=%b exp=1", sb_if.stall); end
    wb(5'd7, 1'b1, 1'b0);
    step();
    checks++; if (sb_if.busy_g !== '0) begin failures++; $display("FAIL same_wb_busy got=%h exp=0", sb_if.busy_g); end
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL same_wb_stall got=%b exp=0", sb_if.stall); end
    clear_inputs();
  endtask

  task automatic test_flush();
    issue(5'd2, 1'b1, 1'b0, 3'd4);
    step();
    clear_inputs();
    sb_if.flush = 1'b1;
    sb_if.chk_s = 5'd2; sb_if.chk_from_g = 3'b010;
    issue(5'd11, 1'b0, 1'b1, 3'd1);
    #1;
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL flush_pre_stall got=%b exp=1", sb_if.stall); end
    step();
    sb_if.flush = 1'b0;
    sb_if.issue_valid = 1'b0;
    #1;
    checks++; if (sb_if.busy_g !== '0) begin failures++; $display("FAIL flush_busy_g got=%h exp=0", sb_if.busy_g); end
    checks++; if (sb_if.busy_f !== '0) begin failures++; $display("FAIL flush_busy_f got=%h exp=0", sb_if.busy_f); end
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", sb_if.stall); end
    clear_inputs();
  endtask

  task automatic test_stall_blocks_issue();
    issue(5'd1, 1'b1, 1'b0, 3'd5);
    step();
    clear_inputs();
    sb_if.chk_s = 5'd1; sb_if.chk_from_g = 3'b010;
    issue(5'd9, 1'b1, 1'b0, 3'd0);
    #1;
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL blk_stall got=%b exp=1", sb_if.stall); end
    step();
    checks++; if (sb_if.busy_g !== 32'h0000_0002) begin failures++; $display("FAIL blk_busy_g got=%h exp=00000002", sb_if.busy_g); end
    clear_inputs();
    // Writeback to an idle register leaves everything untouched.
    wb(5'd20, 1'b1, 1'b1);
    step();
    clear_inputs();
    checks++; if (sb_if.busy_g !== 32'h0000_0002) begin failures++; $display("FAIL idle_wb_busy_g got=%h exp=00000002", sb_if.busy_g); end
    sb_if.flush = 1'b1;
    step();
    clear_inputs();
  endtask

  task automatic test_dual_dest();
    issue(5'd10, 1'b1, 1'b1, 3'd1);
    step();
    clear_inputs();
    sb_if.chk_d = 5'd10; sb_if.chk_from_f = 3'b001;
    #1;
    checks++; if (sb_if.busy_g !== 32'h0000_0400) begin failures++; $display("FAIL dual_busy_g got=%h exp=00000400", sb_if.busy_g); end
    checks++; if (sb_if.busy_f !== 32'h0000_0400) begin failures++; $display("FAIL dual_busy_f got=%h exp=00000400", sb_if.busy_f); end
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL dual_stall got=%b exp=1", sb_if.stall); end
    step();
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL dual_ready_stall got=%b exp=0", sb_if.stall); end
    clear_inputs();
    sb_if.flush = 1'b1;
    step();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    issue(5'd4, 1'b1, 1'b0, 3'd6);
    step();
    clear_inputs();
    sb_if.chk_d = 5'd4; sb_if.chk_from_g = 3'b001;
    #1;
    checks++; if (sb_if.stall !== 1'b1) begin failures++; $display("FAIL arst_pre_stall got=%b exp=1", sb_if.stall); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (sb_if.busy_g !== '0) begin failures++; $display("FAIL arst_busy_g got=%h exp=0", sb_if.busy_g); end
    checks++; if (sb_if.busy_f !== '0) begin failures++; $display("FAIL arst_busy_f got=%h exp=0", sb_if.busy_f); end
    checks++; if (sb_if.stall !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b exp=0", sb_if.stall); end
    step();
    rst = 1'b0;
    clear_inputs();
    step();
  endtask

`ifdef SCOREBOARD_STATS_EN
  task automatic test_stats();
    checks++; if (sb_if.stall_cycles !== 32'd0) begin failures++; $display("FAIL stats_rst_stall got=%0d exp=0", sb_if.stall_cycles); end
    issue(5'd8, 1'b1, 1'b0, 3'd3);
    step();
    clear_inputs();
    sb_if.chk_s = 5'd8; sb_if.chk_from_g = 3'b010;
    step();
    step();
    step();
    step();
    checks++; if (sb_if.stall_cycles !== 32'd3) begin failures++; $display("FAIL stats_stall_cycles got=%0d exp=3", sb_if.stall_cycles); end
    clear_inputs();
    wb(5'd6, 1'b1, 1'b0);
    step();
    clear_inputs();
    checks++; if (sb_if.wb_orphans !== 16'd1) begin failures++; $display("FAIL stats_wb_orphans got=%0d exp=1", sb_if.wb_orphans); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_wait_countdown();
    test_file_isolation();
    test_issue_wb_same_cycle();
    test_flush();
    test_stall_blocks_issue();
    test_dual_dest();
    test_async_reset();
`ifdef SCOREBOARD_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
